// File: rtl/ctrl_if.sv
// ctrl_if: instruction-fetch stage of the 16-bit Thumb-subset pipeline.
// Owns the PC and issues halfword reads to a synchronous instruction memory.
// It delivers registered instruction words to decode, injects NOP bubbles
// after a branch redirect, and raises o_stall while a data access holds the
// shared memory port.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_mem_data_access  data-access length in cycles (one-cycle pulse)
//   i_branch_taken     redirect request from execute
//   i_branch_target    redirect address (bit 0 ignored)
//   o_imem_req         instruction read strobe
//   o_imem_addr        instruction read address
//   i_imem_rdata       read data, valid the cycle after o_imem_req
//   o_ir / o_pc_r      instruction word to decode and its address
//   o_stall            pipeline stall (also feeds the decode stall)
module ctrl_if #(
   parameter int unsigned     AW        = 16,
   parameter logic [AW-1:0]   RESET_PC  = '0,
   parameter logic [15:0]     NOP_INSTR = 16'hBF00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    i_mem_data_access,
   input  logic          i_branch_taken,
   input  logic [AW-1:0] i_branch_target,
   output logic          o_imem_req,
   output logic [AW-1:0] o_imem_addr,
   input  logic [15:0]   i_imem_rdata,
   output logic [15:0]   o_ir,
   output logic [AW-1:0] o_pc_r,
   output logic          o_stall
);

   logic [AW-1:0] pc_q, pc_d;
   logic          req_q, req_d;
   logic [AW-1:0] req_pc_q, req_pc_d;
   logic          skid_valid_q, skid_valid_d;
   logic [15:0]   skid_data_q, skid_data_d;
   logic [AW-1:0] skid_pc_q, skid_pc_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [15:0]   ir_q, ir_d;
   logic [AW-1:0] pc_out_q, pc_out_d;

   logic stall;
   logic issue;
   logic unused_tgt_lsb;

   // Halfword fetch: the target's byte-offset bit is forced to zero.
   assign unused_tgt_lsb = i_branch_target[0];

   // Stall is decoded from the counter register only.
   assign stall = (cnt_q != 4'd0);
   assign issue = !stall && !i_branch_taken;

   assign o_stall     = stall;
   assign o_imem_req  = issue && !rst;
   assign o_imem_addr = pc_q;
   assign o_ir        = ir_q;
   assign o_pc_r      = pc_out_q;

   always_comb begin
      cnt_d = cnt_q;
      if (stall) begin
         cnt_d = cnt_q - 4'd1;
      end else if (i_mem_data_access != 4'd0) begin
         cnt_d = i_mem_data_access;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      req_d        = 1'b0;
      req_pc_d     = req_pc_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_pc_d    = skid_pc_q;
      ir_d         = ir_q;
      pc_out_d     = pc_out_q;

      if (issue) begin
         pc_d     = pc_q + AW'(2);
         req_d    = 1'b1;
         req_pc_d = pc_q;
      end

      // A redirect drops both the in-flight response and any skid entry.
      if (i_branch_taken) begin
         pc_d         = {i_branch_target[AW-1:1], 1'b0};
         skid_valid_d = 1'b0;
         ir_d         = NOP_INSTR;
      end else if (stall && req_q) begin
         // Only the first stall cycle can see a response in flight.
         skid_valid_d = 1'b1;
         skid_data_d  = i_imem_rdata;
         skid_pc_d    = req_pc_q;
      end else if (stall) begin
         ir_d = ir_q;
      end else if (skid_valid_q) begin
         ir_d         = skid_data_q;
         pc_out_d     = skid_pc_q;
         skid_valid_d = 1'b0;
      end else if (req_q) begin
         ir_d     = i_imem_rdata;
         pc_out_d = req_pc_q;
      end else begin
         ir_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         req_pc_q     <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_pc_q    <= '0;
         cnt_q        <= 4'd0;
         ir_q         <= NOP_INSTR;
         pc_out_q     <= '0;
      end else begin
         pc_q         <= pc_d;
         req_q        <= req_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_pc_q    <= skid_pc_d;
         cnt_q        <= cnt_d;
         ir_q         <= ir_d;
         pc_out_q     <= pc_out_d;
      end
   end

endmodule

// File: tb/tb_ctrl_if.sv
// tb_ctrl_if: directed bench for the ctrl_if fetch stage.
// Expected fetch addresses are queued by stimulus; a monitor pops on each new word.
module tb_ctrl_if;

   localparam logic [15:0] NOP = 16'hBF00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  acc = 4'd0;
   logic        br = 1'b0;
   logic [15:0] tgt = 16'h0000;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = 16'h0000;
   logic [15:0] ir;
   logic [15:0] pc_r;
   logic        stall;

   always #5 clk = ~clk;

   ctrl_if dut (
      .clk               (clk),
      .rst               (rst),
      .i_mem_data_access (acc),
      .i_branch_taken    (br),
      .i_branch_target   (tgt),
      .o_imem_req        (imem_req),
      .o_imem_addr       (imem_addr),
      .i_imem_rdata      (imem_rdata),
      .o_ir              (ir),
      .o_pc_r            (pc_r),
      .o_stall           (stall)
   );

   function automatic logic [15:0] word(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // Synchronous instruction memory; idle cycles return a marker word.
   always @(posedge clk)
      imem_rdata <= imem_req ? word(imem_addr) : 16'hDEAD;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] sb_q[$];
   int          exp_addr[$];
   int          exp_stall[$];
   int          exp_nop[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: a new non-NOP word (ir,pc) on o_ir is one delivery.
   logic        last_real = 1'b0;
   logic [15:0] last_ir = 16'h0;
   logic [15:0] last_pc = 16'h0;
   logic [15:0] mon_e;

   always @(negedge clk) begin
      if (rst) begin
         last_real = 1'b0;
      end else begin
         if (ir !== NOP &&
             !(last_real && ir === last_ir && pc_r === last_pc)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL deliver: unexpected pc %h ir %h", pc_r, ir);
            end else begin
               mon_e = sb_q.pop_front();
               if (pc_r !== mon_e || ir !== word(mon_e)) begin
                  n_err++;
                  $display("FAIL deliver: got pc %h ir %h expected pc %h ir %h",
                           pc_r, ir, mon_e, word(mon_e));
               end
            end
         end
         last_real = (ir !== NOP);
         last_ir   = ir;
         last_pc   = pc_r;
      end
   end

   task automatic push(input logic [15:0] a);
      sb_q.push_back(a);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      acc = 4'd0;
      br  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ir", 32'(ir), 32'(NOP));
      chk("rst_pc", 32'(pc_r), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      rst = 1'b0;
   endtask

   // Drive n cycles from reset release and check per-cycle outputs.
   task automatic run(input int n, input int acc_c, input logic [3:0] acc_v,
                      input int br_c, input logic [15:0] br_t);
      for (int c = 0; c < n; c++) begin
         acc = (c == acc_c) ? acc_v : 4'd0;
         br  = (c == br_c);
         tgt = br_t;
         #1;
         chk($sformatf("stall_c%0d", c), 32'(stall), 32'(exp_stall[c]));
         if (exp_addr[c] < 0) begin
            chk($sformatf("req_c%0d", c), 32'(imem_req), 32'h0);
         end else begin
            chk($sformatf("req_c%0d", c), 32'(imem_req), 32'h1);
            chk($sformatf("addr_c%0d", c), 32'(imem_addr), 32'(exp_addr[c]));
         end
         foreach (exp_nop[k])
            if (exp_nop[k] == c)
               chk($sformatf("nop_c%0d", c), 32'(ir), 32'(NOP));
         @(posedge clk);
         #1;
      end
      acc = 4'd0;
      br  = 1'b0;
   endtask

   task automatic drain(input string nm);
      chk(nm, 32'(sb_q.size()), 32'h0);
   endtask

   initial begin
      // Plain streaming after reset.
      do_reset();
      exp_addr  = '{0, 2, 4, 6, 8, 10, 12, 14};
      exp_stall = '{0, 0, 0, 0, 0, 0, 0, 0};
      exp_nop   = '{0, 1};
      push(16'h0000); push(16'h0002); push(16'h0004);
      push(16'h0006); push(16'h0008); push(16'h000A);
      run(8, -1, 4'd0, -1, 16'h0);
      drain("drain_stream");

      // Two-cycle data access while streaming; word 4 goes via the skid.
      do_reset();
      exp_addr  = '{0, 2, 4, -1, -1, 6, 8, 10, 12, 14};
      exp_stall = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
      exp_nop   = '{0, 1};
      push(16'h0000); push(16'h0002); push(16'h0004);
      push(16'h0006); push(16'h0008); push(16'h000A);
      run(10, 2, 4'd2, -1, 16'h0);
      drain("drain_stall");

      // Branch to an odd target; two bubbles, in-flight word 4 dropped.
      do_reset();
      exp_addr  = '{0, 2, 4, -1, 'h40, 'h42, 'h44, 'h46, 'h48, 'h4A};
      exp_stall = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_nop   = '{0, 1, 4, 5};
      push(16'h0000); push(16'h0002); push(16'h0040);
      push(16'h0042); push(16'h0044); push(16'h0046);
      run(10, -1, 4'd0, 3, 16'h0041);
      drain("drain_branch");

      // Branch in the second stall cycle; skid word 4 never appears.
      do_reset();
      exp_addr  = '{0, 2, 4, -1, -1, 'h100, 'h102, 'h104, 'h106, 'h108};
      exp_stall = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
      exp_nop   = '{0, 1, 5, 6};
      push(16'h0000); push(16'h0002); push(16'h0100);
      push(16'h0102); push(16'h0104);
      run(10, 2, 4'd2, 4, 16'h0100);
      drain("drain_br_stall");

      // Address wrap from 0xFFFE to 0x0000.
      do_reset();
      exp_addr  = '{-1, 'hFFFE, 0, 2, 4, 6, 8};
      exp_stall = '{0, 0, 0, 0, 0, 0, 0};
      exp_nop   = '{0, 1, 2};
      push(16'hFFFE); push(16'h0000); push(16'h0002); push(16'h0004);
      run(7, -1, 4'd0, 0, 16'hFFFE);
      drain("drain_wrap");

      // Reset while the stall counter is at 1 with a skid entry held.
      do_reset();
      exp_addr  = '{0, 2, 4, -1};
      exp_stall = '{0, 0, 0, 1};
      exp_nop   = '{0, 1};
      push(16'h0000); push(16'h0002);
      run(4, 2, 4'd2, -1, 16'h0);
      drain("drain_pre_rst");
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_stall", 32'(stall), 32'h0);
      chk("midrst_ir", 32'(ir), 32'(NOP));
      do_reset();
      exp_addr  = '{0, 2, 4, 6, 8, 10};
      exp_stall = '{0, 0, 0, 0, 0, 0};
      exp_nop   = '{0, 1};
      push(16'h0000); push(16'h0002); push(16'h0004); push(16'h0006);
      run(6, -1, 4'd0, -1, 16'h0);
      drain("drain_restart");

      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
